// File: rtl/multi_tank_overlay.sv
// multi_tank_overlay: draws up to NUM_TANKS rectangular tank sprites (plus
// optional HP bars) over the VGA pixel stream. Each channel has its own HP,
// hit-flash invulnerability window and death/revive state. Timing and pixel
// data pass through a fixed 2-stage pipeline.
// Optional feature macro: TANK_OVL_HPBAR_EN (defined = HP bars drawn).
module multi_tank_overlay #(
  parameter int NUM_TANKS    = 2,
  parameter int TANK_W       = 64,
  parameter int TANK_H       = 64,
  parameter int HP_INIT      = 64,
  parameter int HP_DMG       = 8,
  parameter int FLASH_FRAMES = 8,
  parameter int HP_BAR_H     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [10:0]             hcount_in,
  input  logic [9:0]              vcount_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    hblnk_in,
  input  logic                    vblnk_in,
  input  logic [11:0]             rgb_in,
  input  logic [NUM_TANKS*10-1:0] tank_x,
  input  logic [NUM_TANKS*10-1:0] tank_y,
  input  logic [NUM_TANKS*12-1:0] tank_color,
  input  logic [NUM_TANKS-1:0]    hit,
  input  logic [NUM_TANKS-1:0]    revive,
  output logic [10:0]             hcount_out,
  output logic [9:0]              vcount_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    hblnk_out,
  output logic                    vblnk_out,
  output logic [11:0]             rgb_out,
  output logic [NUM_TANKS*8-1:0]  hp_state,
  output logic [NUM_TANKS-1:0]    alive
);

  typedef enum logic [1:0] {ST_ALIVE, ST_FLASH, ST_DEAD} tank_state_t;

  localparam logic [11:0] TW12    = 12'(TANK_W);
  localparam logic [11:0] TH12    = 12'(TANK_H);
  localparam logic [7:0]  HP_FULL = 8'(HP_INIT);
  localparam logic [7:0]  DMG8    = 8'(HP_DMG);
  localparam logic [3:0]  FLASH4  = 4'(FLASH_FRAMES);

  // Per-channel state
  tank_state_t state_reg     [NUM_TANKS];
  logic [7:0]  hp_reg        [NUM_TANKS];
  logic [3:0]  flash_cnt_reg [NUM_TANKS];
  logic [9:0]  pos_x_reg     [NUM_TANKS];
  logic [9:0]  pos_y_reg     [NUM_TANKS];
  logic [11:0] color_reg     [NUM_TANKS];
  logic [11:0] spr_color     [NUM_TANKS];

  // Stage-1 pipeline registers
  logic [10:0] s1_hcount_reg;
  logic [9:0]  s1_vcount_reg;
  logic        s1_hsync_reg, s1_vsync_reg, s1_hblnk_reg, s1_vblnk_reg;
  logic [11:0] s1_rgb_reg;
  logic [NUM_TANKS-1:0] s1_sprite_reg;
  logic [NUM_TANKS-1:0] s1_bar_reg;
  logic [NUM_TANKS-1:0] s1_green_reg;

  logic        vsync_prev_reg;
  logic        frame_tick;
  logic [11:0] h12, v12;
  logic [11:0] rgb_next;

  assign frame_tick = vsync_in & ~vsync_prev_reg;
  assign h12 = {1'b0, hcount_in};
  assign v12 = {2'b0, vcount_in};

  // Remember previous vsync to find its rising edge (frame tick)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vsync_prev_reg <= 1'b0;
    else      vsync_prev_reg <= vsync_in;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TANKS; gi++) begin : g_tank
      logic [11:0] x12, y12;
      logic        in_sprite;

      assign x12 = {2'b0, pos_x_reg[gi]};
      assign y12 = {2'b0, pos_y_reg[gi]};
      assign in_sprite = (h12 >= x12) && (h12 < x12 + TW12) &&
                         (v12 >= y12) && (v12 < y12 + TH12);

      // Flash colour alternates with the low bit of the frame countdown
      assign spr_color[gi] = (state_reg[gi] == ST_DEAD) ? 12'h888 :
                             ((state_reg[gi] == ST_FLASH) && flash_cnt_reg[gi][0]) ?
                             ~color_reg[gi] : color_reg[gi];

      assign hp_state[8*gi +: 8] = hp_reg[gi];
      assign alive[gi]           = (state_reg[gi] != ST_DEAD);

      // Channel FSM plus frame-synchronous latching of position/colour
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg[gi]     <= ST_ALIVE;
          hp_reg[gi]        <= HP_FULL;
          flash_cnt_reg[gi] <= 4'd0;
          pos_x_reg[gi]     <= 10'd0;
          pos_y_reg[gi]     <= 10'd0;
          color_reg[gi]     <= 12'd0;
        end else begin
          if (frame_tick) begin
            pos_x_reg[gi] <= tank_x[10*gi +: 10];
            pos_y_reg[gi] <= tank_y[10*gi +: 10];
            color_reg[gi] <= tank_color[12*gi +: 12];
          end
          if (revive[gi]) begin
            state_reg[gi]     <= ST_ALIVE;
            hp_reg[gi]        <= HP_FULL;
            flash_cnt_reg[gi] <= 4'd0;
          end else begin
            case (state_reg[gi])
              ST_ALIVE: begin
                if (hit[gi]) begin
                  if (hp_reg[gi] <= DMG8) begin
                    hp_reg[gi]    <= 8'd0;
                    state_reg[gi] <= ST_DEAD;
                  end else begin
                    hp_reg[gi]        <= hp_reg[gi] - DMG8;
                    state_reg[gi]     <= ST_FLASH;
                    flash_cnt_reg[gi] <= FLASH4;
                  end
                end
              end
              ST_FLASH: begin
                if (frame_tick) begin
                  if (flash_cnt_reg[gi] <= 4'd1) begin
                    flash_cnt_reg[gi] <= 4'd0;
                    state_reg[gi]     <= ST_ALIVE;
                  end else begin
                    flash_cnt_reg[gi] <= flash_cnt_reg[gi] - 4'd1;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      end

      // Stage 1: sprite hit test for this channel
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) s1_sprite_reg[gi] <= 1'b0;
        else      s1_sprite_reg[gi] <= in_sprite;
      end

`ifdef TANK_OVL_HPBAR_EN
      localparam logic [11:0] BAR_OFS = 12'(HP_BAR_H + 2);
      logic in_bar, bar_green;
      // Bar rows end 2 above the sprite; bars that would start above row 0 are dropped
      assign in_bar = (y12 >= BAR_OFS) && (v12 >= y12 - BAR_OFS) &&
                      (v12 < y12 - 12'd2) &&
                      (h12 >= x12) && (h12 < x12 + 12'(HP_INIT));
      assign bar_green = (h12 - x12) < {4'b0, hp_reg[gi]};

      // Stage 1: HP bar hit test and green/red split for this channel
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s1_bar_reg[gi]   <= 1'b0;
          s1_green_reg[gi] <= 1'b0;
        end else begin
          s1_bar_reg[gi]   <= in_bar;
          s1_green_reg[gi] <= bar_green;
        end
      end
`else
      assign s1_bar_reg[gi]   = 1'b0;
      assign s1_green_reg[gi] = 1'b0;
`endif
    end
  endgenerate

  // Stage 1: carry timing and background pixel alongside the hit tests
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_hcount_reg <= 11'd0;
      s1_vcount_reg <= 10'd0;
      s1_hsync_reg  <= 1'b0;
      s1_vsync_reg  <= 1'b0;
      s1_hblnk_reg  <= 1'b0;
      s1_vblnk_reg  <= 1'b0;
      s1_rgb_reg    <= 12'd0;
    end else begin
      s1_hcount_reg <= hcount_in;
      s1_vcount_reg <= vcount_in;
      s1_hsync_reg  <= hsync_in;
      s1_vsync_reg  <= vsync_in;
      s1_hblnk_reg  <= hblnk_in;
      s1_vblnk_reg  <= vblnk_in;
      s1_rgb_reg    <= rgb_in;
    end
  end

  // Stage 2 mux: walk from highest index down so the lowest index wins
  always_comb begin
    rgb_next = s1_rgb_reg;
    for (int i = NUM_TANKS - 1; i >= 0; i--) begin
      if (s1_sprite_reg[i]) begin
        rgb_next = spr_color[i];
      end else if (s1_bar_reg[i] && (state_reg[i] != ST_DEAD)) begin
        rgb_next = s1_green_reg[i] ? 12'h0F0 : 12'hF00;
      end
    end
    if (s1_hblnk_reg || s1_vblnk_reg) rgb_next = 12'h000;
  end

  // Stage 2: output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_out <= 11'd0;
      vcount_out <= 10'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'd0;
    end else begin
      hcount_out <= s1_hcount_reg;
      vcount_out <= s1_vcount_reg;
      hsync_out  <= s1_hsync_reg;
      vsync_out  <= s1_vsync_reg;
      hblnk_out  <= s1_hblnk_reg;
      vblnk_out  <= s1_vblnk_reg;
      rgb_out    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_multi_tank_overlay.sv
// Scoreboard bench for multi_tank_overlay: probe pixels push expected colours,
// a negedge monitor pops and compares them (including 2-cycle latency).
module tb_multi_tank_overlay;
  localparam int N = 2;
  localparam logic [10:0] IDLE_H = 11'h7FF;
  localparam logic [9:0]  IDLE_V = 10'h3FF;
`ifdef TANK_OVL_HPBAR_EN
  localparam bit BAR = 1'b1;
`else
  localparam bit BAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [10:0] hcount_in, hcount_out;
  logic [9:0]  vcount_in, vcount_out;
  logic hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic [N*10-1:0] tank_x, tank_y;
  logic [N*12-1:0] tank_color;
  logic [N-1:0] hit, revive, alive;
  logic [N*8-1:0] hp_state;

  always #5 clk = ~clk;

  multi_tank_overlay #(.NUM_TANKS(N)) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .tank_x(tank_x), .tank_y(tank_y), .tank_color(tank_color),
    .hit(hit), .revive(revive),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .hp_state(hp_state), .alive(alive)
  );

  typedef struct {
    int h;
    int v;
    logic [11:0] rgb;
    int issue;
  } exp_t;

  exp_t sbq[$];
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any non-idle output pixel must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && hcount_out != IDLE_H) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pixel h=%0d v=%0d rgb=%h, required none", hcount_out, vcount_out, rgb_out);
      end else begin
        e = sbq.pop_front();
        if (hcount_out != 11'(e.h) || vcount_out != 10'(e.v) || rgb_out != e.rgb || (cyc - e.issue) != 2) begin
          n_bad++;
          $display("FAIL pixel(%0d,%0d) got h=%0d v=%0d rgb=%h lat=%0d, required rgb=%h lat=2",
                   e.h, e.v, hcount_out, vcount_out, rgb_out, cyc - e.issue, e.rgb);
        end else begin
          $display("pixel(%0d,%0d) rgb=%h ok", e.h, e.v, rgb_out);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end else begin
      $display("%s = %0d ok", name, got);
    end
  endtask

  task automatic probe(input int h, input int v, input logic [11:0] bg,
                       input logic [11:0] want, input logic hb = 1'b0, input logic vb = 1'b0);
    exp_t e;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    rgb_in    = bg;
    hblnk_in  = hb;
    vblnk_in  = vb;
    e.h = h; e.v = v; e.rgb = want; e.issue = cyc;
    sbq.push_back(e);
    tick();
    hcount_in = IDLE_H;
    vcount_in = IDLE_V;
    hblnk_in  = 1'b0;
    vblnk_in  = 1'b0;
    rgb_in    = 12'h555;
  endtask

  task automatic frame();
    vsync_in = 1'b1;
    tick();
    tick();
    vsync_in = 1'b0;
    tick();
  endtask

  task automatic pulse(input logic [N-1:0] h, input logic [N-1:0] r);
    hit = h;
    revive = r;
    tick();
    hit = '0;
    revive = '0;
    tick();
  endtask

  task automatic set_tank(input int i, input int x, input int y, input logic [11:0] c);
    tank_x[10*i +: 10]     = 10'(x);
    tank_y[10*i +: 10]     = 10'(y);
    tank_color[12*i +: 12] = c;
  endtask

  // Hard bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] want;
    int hp_exp;
    rst = 1'b0;
    hcount_in = IDLE_H; vcount_in = IDLE_V;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = 12'h555; tank_x = '0; tank_y = '0; tank_color = '0;
    hit = '0; revive = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_hcount_out", int'(hcount_out), 0);
    chk("rst_rgb_out", int'(rgb_out), 0);
    chk("rst_hp0", int'(hp_state[7:0]), 64);
    chk("rst_hp1", int'(hp_state[15:8]), 64);
    chk("rst_alive", int'(alive), 3);

    rst = 1'b1;
    repeat (3) tick();
    mon_en = 1'b1;

    // Basic sprite drawing
    set_tank(0, 100, 200, 12'hF0F);
    set_tank(1, 900, 900, 12'h0AA);
    frame();
    probe(100, 200, 12'h321, 12'hF0F);
    probe(164, 200, 12'h321, 12'h321);
    probe(163, 263, 12'h456, 12'hF0F);
    probe(100, 264, 12'h456, 12'h456);
    probe(99, 200, 12'h456, 12'h456);
    chk("hp0_start", int'(hp_state[7:0]), 64);

    // Hit -> FLASH, second hit ignored, colour alternates over 8 ticks
    pulse(2'b01, 2'b00);
    chk("hp0_after_hit", int'(hp_state[7:0]), 56);
    chk("alive_after_hit", int'(alive), 3);
    probe(100, 200, 12'h321, 12'hF0F);
    pulse(2'b01, 2'b00);
    chk("hp0_hit_in_flash", int'(hp_state[7:0]), 56);
    for (int k = 1; k <= 8; k++) begin
      frame();
      want = (k == 8) ? 12'hF0F : (((8 - k) % 2) == 1 ? 12'h0F0 : 12'hF0F);
      probe(100, 200, 12'h321, want);
    end

    // HP bar at (50,40) with hp=56
    set_tank(0, 50, 40, 12'hF0F);
    frame();
    probe(50, 34, 12'h111, BAR ? 12'h0F0 : 12'h111);
    probe(105, 34, 12'h111, BAR ? 12'h0F0 : 12'h111);
    probe(106, 34, 12'h111, BAR ? 12'hF00 : 12'h111);
    probe(113, 34, 12'h111, BAR ? 12'hF00 : 12'h111);
    probe(114, 34, 12'h111, 12'h111);
    probe(50, 33, 12'h111, 12'h111);
    probe(50, 37, 12'h111, BAR ? 12'h0F0 : 12'h111);
    probe(50, 38, 12'h111, 12'h111);
    probe(50, 40, 12'h111, 12'hF0F);

    // Tank near top: no bar at all
    set_tank(0, 50, 3, 12'hF0F);
    frame();
    probe(50, 0, 12'h222, 12'h222);
    probe(60, 1, 12'h222, 12'h222);
    probe(50, 3, 12'h222, 12'hF0F);

    // Blanking forces black
    probe(50, 3, 12'h222, 12'h000, 1'b1, 1'b0);
    probe(50, 3, 12'h222, 12'h000, 1'b0, 1'b1);

    // Mid-frame position change takes effect only after vsync rise
    tank_x[9:0] = 10'd200;
    tick();
    tick();
    probe(50, 3, 12'h333, 12'hF0F);
    probe(200, 3, 12'h333, 12'h333);
    frame();
    probe(200, 3, 12'h333, 12'hF0F);
    probe(50, 3, 12'h333, 12'h333);

    // Hits spaced beyond the flash window until death
    for (int k = 1; k <= 7; k++) begin
      pulse(2'b01, 2'b00);
      hp_exp = 56 - 8 * k;
      chk("hp0_drain", int'(hp_state[7:0]), hp_exp);
      if (hp_exp != 0) repeat (8) frame();
    end
    chk("alive_dead", int'(alive), 2);
    probe(200, 3, 12'h444, 12'h888);
    set_tank(0, 50, 40, 12'hF0F);
    frame();
    probe(50, 34, 12'h444, 12'h444);
    probe(50, 40, 12'h444, 12'h888);
    pulse(2'b01, 2'b00);
    chk("hp0_hit_dead", int'(hp_state[7:0]), 0);
    chk("alive_hit_dead", int'(alive), 2);
    pulse(2'b00, 2'b01);
    chk("hp0_revive", int'(hp_state[7:0]), 64);
    chk("alive_revive", int'(alive), 3);
    probe(50, 40, 12'h444, 12'hF0F);
    probe(113, 34, 12'h444, BAR ? 12'h0F0 : 12'h444);
    probe(114, 34, 12'h444, 12'h444);

    // Overlapping tanks: tank0 wins
    set_tank(0, 300, 300, 12'hF0F);
    set_tank(1, 330, 300, 12'h0AA);
    frame();
    probe(340, 300, 12'h666, 12'hF0F);
    probe(370, 300, 12'h666, 12'h0AA);
    probe(320, 300, 12'h666, 12'hF0F);
    probe(394, 300, 12'h666, 12'h666);

    // Revive beats simultaneous hit on tank1
    pulse(2'b10, 2'b10);
    chk("hp1_hit_revive", int'(hp_state[15:8]), 64);
    chk("alive_hit_revive", int'(alive), 3);
    probe(370, 300, 12'h666, 12'h0AA);

    // Simultaneous hits on both channels handled independently
    pulse(2'b11, 2'b00);
    chk("hp_both_hit", int'(hp_state), 16'h3838);
    probe(370, 300, 12'h666, 12'h0AA);
    frame();
    probe(370, 300, 12'h666, 12'hF55);
    probe(340, 300, 12'h666, 12'h0F0);

    repeat (10) tick();
    chk("scoreboard_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
